// File: rtl/mv_pkg.sv
// Shared types and constants for the 3x3 matrix-vector operand loader.
package mv_pkg;

    localparam int unsigned MV_DATA_W = 8;
    localparam int unsigned MV_N      = 3;
    localparam int unsigned MV_ELEMS  = 12;
    localparam int unsigned MV_IDX_W  = 4;

    localparam logic [MV_IDX_W-1:0] IDX_B1   = MV_IDX_W'(9);
    localparam logic [MV_IDX_W-1:0] IDX_LAST = MV_IDX_W'(11);

    typedef enum logic {
        ST_LOAD = 1'b0,
        ST_HOLD = 1'b1
    } mv_state_e;

    // Row-major slot of matrix element (row, col), both zero-based.
    function automatic int unsigned mat_idx(input int unsigned row, input int unsigned col);
        return row * MV_N + col;
    endfunction

endpackage

// File: rtl/mv_elem_counter.sv
// Mod-12 element index counter with increment, sync load-to-1 and wrap flag.
module mv_elem_counter
    import mv_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                inc_i,
    input  logic                load1_i,
    output logic [MV_IDX_W-1:0] cnt_o,
    output logic                wrap_o
);

    logic [MV_IDX_W-1:0] cnt_q;
    logic [MV_IDX_W-1:0] cnt_d;

    assign wrap_o = inc_i & ~load1_i & (cnt_q == IDX_LAST);
    assign cnt_o  = cnt_q;

    // Load-to-1 takes priority: the resynchronising beat itself occupies slot 0.
    always_comb begin
        cnt_d = cnt_q;
        if (load1_i) begin
            cnt_d = MV_IDX_W'(1);
        end else if (inc_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + MV_IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mv_operand_loader.sv
// Serial-to-parallel operand frame loader for the 3x3 MAC stage.
// Optional frame alignment check enabled by defining MV_LOADER_FRAME_CHK_EN.
module mv_operand_loader
    import mv_pkg::*;
#(
    parameter int unsigned DATA_W       = MV_DATA_W,
    parameter bit          AUTO_RELEASE = 1'b0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   s_data,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_first,
    output logic [DATA_W-1:0]   a11,
    output logic [DATA_W-1:0]   a12,
    output logic [DATA_W-1:0]   a13,
    output logic [DATA_W-1:0]   a21,
    output logic [DATA_W-1:0]   a22,
    output logic [DATA_W-1:0]   a23,
    output logic [DATA_W-1:0]   a31,
    output logic [DATA_W-1:0]   a32,
    output logic [DATA_W-1:0]   a33,
    output logic [DATA_W-1:0]   b1,
    output logic [DATA_W-1:0]   b2,
    output logic [DATA_W-1:0]   b3,
    output logic                out_valid,
    input  logic                out_ack,
    output logic [MV_IDX_W-1:0] elem_idx,
    output logic                frame_err
);

    mv_state_e           state_q;
    logic                ready_q;
    logic                valid_q;
    logic                err_q;
    logic [DATA_W-1:0]   opnd_q [MV_ELEMS];

    logic                beat;
    logic                resync;
    logic                err_set;
    logic                wrap;
    logic [MV_IDX_W-1:0] idx;
    logic [MV_IDX_W-1:0] wr_idx;

    // ready_q is only ever high in LOAD, so it doubles as the state qualifier.
    assign beat = s_valid & ready_q;

`ifdef MV_LOADER_FRAME_CHK_EN
    assign resync  = beat & s_first & (idx != '0);
    assign err_set = resync | (beat & ~s_first & (idx == '0));
`else
    logic unused_first;
    assign unused_first = s_first;
    assign resync       = 1'b0;
    assign err_set      = 1'b0;
`endif

    assign wr_idx = resync ? '0 : idx;

    mv_elem_counter u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (beat & ~resync),
        .load1_i (resync),
        .cnt_o   (idx),
        .wrap_o  (wrap)
    );

    // Frame FSM; s_ready and out_valid are registered copies of the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_LOAD;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_q;
            ready_q <= ready_q;
            valid_q <= valid_q;
            case (state_q)
                ST_LOAD: begin
                    if (wrap) begin
                        state_q <= ST_HOLD;
                        ready_q <= 1'b0;
                        valid_q <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (AUTO_RELEASE || out_ack) begin
                        state_q <= ST_LOAD;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                    ready_q <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Decoded operand write; registers are overwritten in place, never cleared between frames.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(MV_ELEMS); i++) begin
                opnd_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(MV_ELEMS); i++) begin
                if (beat && (wr_idx == MV_IDX_W'(i))) begin
                    opnd_q[i] <= s_data;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign a11 = opnd_q[mat_idx(0, 0)];
    assign a12 = opnd_q[mat_idx(0, 1)];
    assign a13 = opnd_q[mat_idx(0, 2)];
    assign a21 = opnd_q[mat_idx(1, 0)];
    assign a22 = opnd_q[mat_idx(1, 1)];
    assign a23 = opnd_q[mat_idx(1, 2)];
    assign a31 = opnd_q[mat_idx(2, 0)];
    assign a32 = opnd_q[mat_idx(2, 1)];
    assign a33 = opnd_q[mat_idx(2, 2)];
    assign b1  = opnd_q[IDX_B1];
    assign b2  = opnd_q[IDX_B1 + MV_IDX_W'(1)];
    assign b3  = opnd_q[IDX_LAST];

    assign s_ready   = ready_q;
    assign out_valid = valid_q;
    assign elem_idx  = idx;
    assign frame_err = err_q;

endmodule

// File: tb/tb_mv_operand_loader.sv
// Scoreboard bench for mv_operand_loader: hold-until-ack instance and auto-release instance.
module tb_mv_operand_loader;

    localparam int unsigned W = 8;
    typedef logic [12*W-1:0] frame_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic [W-1:0] sd0, sd1;
    logic         sv0, sv1, sf0, sf1, sr0, sr1, ov0, ov1, ack0, fe0, fe1;
    logic         ack1 = 1'b0;
    logic [3:0]   ei0, ei1;
    logic [W-1:0] op0 [12];
    logic [W-1:0] op1 [12];

    int vectors = 0;
    int fails   = 0;

    int unsigned m_idx [2];
    frame_t      m_fr  [2];
    logic        m_err [2];
    frame_t      q0 [$];
    frame_t      q1 [$];
    frame_t      last_fr;

    int unsigned c_q [3];
    int          ar_cycles = 0;

    mv_operand_loader #(.DATA_W(W), .AUTO_RELEASE(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .s_data(sd0), .s_valid(sv0), .s_ready(sr0), .s_first(sf0),
        .a11(op0[0]), .a12(op0[1]), .a13(op0[2]), .a21(op0[3]), .a22(op0[4]), .a23(op0[5]),
        .a31(op0[6]), .a32(op0[7]), .a33(op0[8]), .b1(op0[9]), .b2(op0[10]), .b3(op0[11]),
        .out_valid(ov0), .out_ack(ack0), .elem_idx(ei0), .frame_err(fe0)
    );

    mv_operand_loader #(.DATA_W(W), .AUTO_RELEASE(1'b1)) dut_ar (
        .clk(clk), .reset_n(reset_n), .s_data(sd1), .s_valid(sv1), .s_ready(sr1), .s_first(sf1),
        .a11(op1[0]), .a12(op1[1]), .a13(op1[2]), .a21(op1[3]), .a22(op1[4]), .a23(op1[5]),
        .a31(op1[6]), .a32(op1[7]), .a33(op1[8]), .b1(op1[9]), .b2(op1[10]), .b3(op1[11]),
        .out_valid(ov1), .out_ack(ack1), .elem_idx(ei1), .frame_err(fe1)
    );

    function automatic int unsigned mac_obs(input int r);
        int unsigned s = 0;
        for (int k = 0; k < 3; k++) s += int'(op0[r*3+k]) * int'(op0[9+k]);
        return s;
    endfunction

    function automatic int unsigned mac_exp(input frame_t f, input int r);
        int unsigned s = 0;
        for (int k = 0; k < 3; k++)
            s += int'(f[(11-(r*3+k))*W +: W]) * int'(f[(11-(9+k))*W +: W]);
        return s;
    endfunction

    // Consumer MAC stage: registers the product whenever the frame is flagged valid.
    always @(posedge clk) begin
        if (ov0) begin
            for (int r = 0; r < 3; r++) c_q[r] <= mac_obs(r);
        end
    end

    always @(negedge clk) begin
        if (ov1) ar_cycles <= ar_cycles + 1;
    end

    function automatic frame_t obs(input int w);
        frame_t f;
        for (int i = 0; i < 12; i++) f[(11-i)*W +: W] = (w == 0) ? op0[i] : op1[i];
        return f;
    endfunction

    function automatic logic rdy(input int w);
        return (w == 0) ? sr0 : sr1;
    endfunction

    function automatic void model_reset();
        for (int w = 0; w < 2; w++) begin
            m_idx[w] = 0;
            m_fr[w]  = '0;
            m_err[w] = 1'b0;
        end
    endfunction

    function automatic void model_beat(input int w, input logic [W-1:0] d, input logic f);
        int unsigned wi = m_idx[w];
`ifdef MV_LOADER_FRAME_CHK_EN
        if (f && wi != 0) begin
            wi = 0;
            m_err[w] = 1'b1;
        end else if (!f && wi == 0) begin
            m_err[w] = 1'b1;
        end
`else
        logic unused_f;
        unused_f = f;
`endif
        m_fr[w][(11-wi)*W +: W] = d;
        if (wi == 11) begin
            m_idx[w] = 0;
            if (w == 0) q0.push_back(m_fr[w]);
            else        q1.push_back(m_fr[w]);
        end else begin
            m_idx[w] = wi + 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
        vectors++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic send(input int w, input logic [W-1:0] d, input logic f);
        int n = 0;
        if (w == 0) begin sv0 = 1'b1; sd0 = d; sf0 = f; end
        else        begin sv1 = 1'b1; sd1 = d; sf1 = f; end
        while (rdy(w) !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("s_ready_wait", 128'(rdy(w)), 128'd1);
        tick();
        if (w == 0) sv0 = 1'b0;
        else        sv1 = 1'b0;
        model_beat(w, d, f);
    endtask

    task automatic expect_frame(input int w, input string tag);
        int sz = (w == 0) ? q0.size() : q1.size();
        chk({tag, "_pending"}, 128'(sz), 128'd1);
        if (sz > 0) begin
            last_fr = (w == 0) ? q0.pop_front() : q1.pop_front();
            chk({tag, "_operands"}, 128'(obs(w)), 128'(last_fr));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sd0 = '0; sd1 = '0; sv0 = 1'b0; sv1 = 1'b0; sf0 = 1'b0; sf1 = 1'b0; ack0 = 1'b0;
        model_reset();

        // Async reset with no clock edge involved
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        chk("rst_operands", 128'(obs(0)), 128'd0);
        chk("rst_out_valid", 128'(ov0), 128'd0);
        chk("rst_elem_idx", 128'(ei0), 128'd0);
        chk("rst_frame_err", 128'(fe0), 128'd0);
        chk("rst_s_ready", 128'(sr0), 128'd0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_ready", 128'(sr0), 128'd1);

        // Reset mid-frame discards the partial frame
        send(0, 8'hA0, 1'b1);
        send(0, 8'hA1, 1'b0);
        send(0, 8'hA2, 1'b0);
        chk("mid_idx", 128'(ei0), 128'd3);
        chk("mid_a11", 128'(op0[0]), 128'hA0);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_idx", 128'(ei0), 128'd0);
        chk("mid_rst_operands", 128'(obs(0)), 128'd0);
        chk("mid_rst_valid", 128'(ov0), 128'd0);
        chk("mid_rst_ready", 128'(sr0), 128'd0);
        model_reset();
        tick();
        reset_n = 1'b1;
        tick();

        // Gapless frame 1..12 and MAC result one cycle later
        for (int i = 1; i <= 12; i++) send(0, 8'(i), (i == 1));
        chk("f1_out_valid", 128'(ov0), 128'd1);
        expect_frame(0, "f1");
        chk("f1_idx_wrap", 128'(ei0), 128'(m_idx[0]));
        chk("f1_ready_low", 128'(sr0), 128'd0);
        chk("f1_b3", 128'(op0[11]), 128'd12);
        tick();
        for (int r = 0; r < 3; r++) chk($sformatf("mac_c%0d", r+1), 128'(c_q[r]), 128'(mac_exp(last_fr, r)));
        chk("mac_c1_const", 128'(c_q[0]), 128'd68);

        // Backpressure in HOLD
        sv0 = 1'b1; sd0 = 8'h55; sf0 = 1'b1;
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("bp_ready", 128'(sr0), 128'd0);
            chk("bp_valid", 128'(ov0), 128'd1);
            chk("bp_stable", 128'(obs(0)), 128'(last_fr));
        end
        ack0 = 1'b1;
        tick();
        ack0 = 1'b0;
        chk("ack_valid_fall", 128'(ov0), 128'd0);
        chk("ack_ready", 128'(sr0), 128'd1);
        chk("ack_no_early_beat", 128'(ei0), 128'd0);
        send(0, 8'h55, 1'b1);
        chk("f2_beat0_idx", 128'(ei0), 128'd1);
        chk("f2_beat0_a11", 128'(op0[0]), 128'h55);

        // s_valid toggling; stray ack during LOAD is ignored
        for (int i = 1; i < 12; i++) begin
            ack0 = (i == 3);
            tick();
            ack0 = 1'b0;
            chk("gap_idx", 128'(ei0), 128'(m_idx[0]));
            chk("gap_valid", 128'(ov0), 128'd0);
            send(0, 8'(8'h60 + i), 1'b0);
        end
        chk("f2_out_valid", 128'(ov0), 128'd1);
        expect_frame(0, "f2");
        ack0 = 1'b1; tick(); ack0 = 1'b0;
        chk("f2_release", 128'(ov0), 128'd0);

        // s_first asserted mid-frame at elem_idx 5
        for (int i = 0; i < 5; i++) send(0, 8'(8'hC0 + i), (i == 0));
        send(0, 8'hE5, 1'b1);
`ifdef MV_LOADER_FRAME_CHK_EN
        chk("chk_err_set", 128'(fe0), 128'd1);
        chk("chk_idx_one", 128'(ei0), 128'd1);
        chk("chk_a11", 128'(op0[0]), 128'hE5);
`else
        chk("chk_err_tied", 128'(fe0), 128'd0);
        chk("chk_idx_six", 128'(ei0), 128'd6);
`endif
        chk("chk_model_a11", 128'(op0[0]), 128'(m_fr[0][11*W +: W]));
        for (int n = 0; n < 12 && m_idx[0] != 0; n++) send(0, 8'(8'hD0 + n), 1'b0);
        chk("chk_out_valid", 128'(ov0), 128'd1);
        expect_frame(0, "chk");
        chk("chk_err_sticky", 128'(fe0), 128'(m_err[0]));
        ack0 = 1'b1; tick(); ack0 = 1'b0;

        // Auto-release instance: two back-to-back frames, single-cycle pulses
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 12; i++) send(1, 8'(16*f + i + 3), (i == 0));
            chk("ar_pulse_high", 128'(ov1), 128'd1);
            expect_frame(1, "ar");
            tick();
            chk("ar_pulse_low", 128'(ov1), 128'd0);
            chk("ar_ready_back", 128'(sr1), 128'd1);
        end
        tick();
        chk("ar_pulse_cycles", 128'(ar_cycles), 128'd2);
        chk("ar_frame_err", 128'(fe1), 128'(m_err[1]));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
